popcnt_seq: RTL and testbench
=============================

Name: popcnt_seq

Overview:
- Multi-cycle sequencer that time-shares one narrow CHUNK-bit popcnt datapath to count ones in an XLEN-bit operand, one slice per cycle.
- Sits in the bit-manipulation unit, between execute-stage issue and writeback.
- Serves cpop and cpopw: a full XLEN count, or a count of the low 32 bits.
- Valid/ready on both sides; supports pipeline flush.

Parameters:
- XLEN, 64, operand width; must be a multiple of CHUNK.
- CHUNK, 16, popcnt datapath slice width; must divide 32.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- InValid  in  1  request valid
- InReady  out  1  block can accept a request
- A  in  XLEN  operand, captured on accept
- W32  in  1  1 = count A[31:0] only (cpopw); captured on accept
- Flush  in  1  abort any operation in flight
- OutValid  out  1  Result valid
- OutReady  in  1  consumer takes Result
- Result  out  $clog2(XLEN)+1  population count, zero-extended
- Busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, OutValid=0, Result=0, accumulator=0, slice index=0, InReady=1.
- States:
  - IDLE: InReady=1. InValid && !Flush → latch A into the operand register and W32; acc=0; idx=0; go to COUNT.
  - COUNT: InReady=0. Each cycle:
    - acc += popcnt(op slice idx), where slice idx = op[idx*CHUNK +: CHUNK].
    - idx++.
    - After the last slice, go to DONE. Last slice is N-1, where N = XLEN/CHUNK, or 32/CHUNK when W32.
  - DONE: OutValid=1, Result=acc.
    - OutReady=1 → back-to-back accept: InReady=1, so InValid in the same cycle captures a new operand and goes straight to COUNT. Otherwise go to IDLE.
    - OutReady=0 → hold Result stable.
- Latency:
  - Accept edge to OutValid is N+1 cycles: 5 for XLEN=64/CHUNK=16; 3 for W32.
  - Throughput is one result per N+1 cycles with back-to-back handshakes.
- Arithmetic:
  - Accumulator width is $clog2(XLEN)+1; the all-ones input (XLEN) must not overflow.
  - Slice count is zero-extended before the add.
- Flush:
  - Any state → IDLE next cycle; OutValid=0 next cycle; Result cleared.
  - Flush has priority over a same-cycle accept and over the DONE handshake. An InValid in a Flush cycle is ignored.
- Operand stability: A and W32 are don't-care after accept.
- Reset asserted mid-COUNT: immediate IDLE; no spurious OutValid after reset_n deasserts.
- Result is registered; no combinational path from A to Result.

Optional Feature:
- Macro: POPCNT_SEQ_EARLY_EXIT_EN.
- When defined, in COUNT the block goes to DONE as soon as all operand bits at or above the current slice are zero (checked on the remaining shifted operand).
  - Latency becomes 2 + index of the highest nonzero slice.
  - A zero operand completes in 2 cycles (accept → one COUNT cycle → DONE).
- When undefined, latency is fixed at N+1. The fixed latency is also available when the macro is defined, by not using the early exit.
- Result must be identical either way.

Decomposition:
- Shared package bmu_pkg:
  - state enum popcnt_seq_state_t {IDLE, COUNT, DONE}.
  - Localparams NSLICE_X = XLEN/CHUNK and NSLICE_W = 32/CHUNK, expressed as functions of the parameters.
- Sub-module: existing popcnt, instantiated once with WIDTH=CHUNK. The block's own logic is the FSM, slice mux, accumulator and operand register.

Test Plan:
- Basic count: A=64'hFFFF_0000_F0F0_0001, W32=0, OutReady=1 → OutValid on accept+5, Result=25.
- W32 mode: A=64'hFFFF_FFFF_8000_0003, W32=1 → Result=3, OutValid on accept+3; upper bits ignored.
- Extremes and stall:
  - A=all-ones → Result=64 (no overflow).
  - A=0 → Result=0.
  - OutReady held 0 for 4 cycles → Result and OutValid stable; InReady=0 throughout.
- Back-to-back:
  - DONE with OutReady=1 and InValid=1 carrying A=64'h1 → first result retires, second accepted same cycle.
  - Second Result=1 exactly 5 cycles later; no idle bubble.
- Flush:
  - Flush in the 2nd COUNT cycle → IDLE next cycle, OutValid never rises.
  - Flush coinciding with InValid in IDLE → request dropped.
  - reset_n pulse mid-COUNT → all outputs at reset values.
- With POPCNT_SEQ_EARLY_EXIT_EN: A=64'h0000_0000_0000_00FF → Result=8 at accept+2; A=64'h8000_0000_0000_0000 → Result=1 at accept+5.

Source files
------------

// File: rtl/bmu_pkg.sv
// Shared bit-manipulation-unit definitions: popcnt sequencer state encoding
// and slice-count helpers derived from the operand and datapath widths.
package bmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } popcnt_seq_state_t;

    function automatic int nslice_x(input int xlen, input int chunk);
        return xlen / chunk;
    endfunction

    function automatic int nslice_w(input int chunk);
        return 32 / chunk;
    endfunction

    localparam int XLEN_DEF  = 64;
    localparam int CHUNK_DEF = 16;
    localparam int NSLICE_X  = nslice_x(XLEN_DEF, CHUNK_DEF);
    localparam int NSLICE_W  = nslice_w(CHUNK_DEF);

endpackage

// File: rtl/popcnt.sv
// Combinational population count of a WIDTH-bit vector.
module popcnt #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         a,
    output logic [$clog2(WIDTH):0]   cnt
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Ripple sum of the individual bits.
    always_comb begin
        cnt = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(a[i]);
        end
    end

endmodule

// File: rtl/popcnt_seq.sv
// Multi-cycle cpop/cpopw sequencer sharing one CHUNK-bit popcnt slice.
// Optional build macro POPCNT_SEQ_EARLY_EXIT_EN ends counting once the remaining operand is zero.
module popcnt_seq
    import bmu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [XLEN-1:0]          A,
    input  logic                     W32,
    input  logic                     Flush,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [$clog2(XLEN):0]    Result,
    output logic                     Busy
);

    localparam int NX = nslice_x(XLEN, CHUNK);
    localparam int NW = nslice_w(CHUNK);
    localparam int RW = $clog2(XLEN) + 1;
    localparam int CW = $clog2(CHUNK) + 1;
    localparam int IW = $clog2(NX + 1);

    popcnt_seq_state_t state_r, state_s;
    logic [XLEN-1:0]   op_r, op_s;
    logic [IW-1:0]     idx_r, idx_s;
    logic [IW-1:0]     last_r, last_s;
    logic [RW-1:0]     acc_r, acc_s;
    logic [CW-1:0]     slice_cnt_s;
    logic [XLEN-1:0]   mask_s;
    logic              in_ready_s;
    logic              early_s;

    // Operand register shifts right each COUNT cycle, so the live slice is always the low CHUNK bits.
    popcnt #(.WIDTH(CHUNK)) u_popcnt (
        .a   (op_r[CHUNK-1:0]),
        .cnt (slice_cnt_s)
    );

    // Early exit: nothing left to count above the slice being consumed now.
    always_comb begin
`ifdef POPCNT_SEQ_EARLY_EXIT_EN
        early_s = ((op_r >> CHUNK) == {XLEN{1'b0}});
`else
        early_s = 1'b0;
`endif
    end

    // Next-state, accumulator and operand-capture logic.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        idx_s      = idx_r;
        last_s     = last_r;
        acc_s      = acc_r;
        in_ready_s = (state_r == IDLE) || ((state_r == DONE) && OutReady);
        mask_s     = W32 ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};

        case (state_r)
            IDLE: begin
                if (InValid) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                acc_s = acc_r + RW'(slice_cnt_s);
                op_s  = op_r >> CHUNK;
                idx_s = idx_r + IW'(1'b1);
                if ((idx_r == last_r) || early_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE: begin
                if (OutReady && InValid) begin
                    state_s = COUNT;
                end else if (OutReady) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Any transition into COUNT out of IDLE/DONE is a fresh accept.
        if ((state_r != COUNT) && (state_s == COUNT)) begin
            op_s   = A & mask_s;
            last_s = W32 ? IW'(NW - 1) : IW'(NX - 1);
            acc_s  = {RW{1'b0}};
            idx_s  = {IW{1'b0}};
        end else begin
            last_s = last_s;
        end

        // Flush overrides both accept and the DONE handshake.
        if (Flush) begin
            state_s = IDLE;
            acc_s   = {RW{1'b0}};
            idx_s   = {IW{1'b0}};
        end else begin
            state_s = state_s;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            op_r    <= {XLEN{1'b0}};
            idx_r   <= {IW{1'b0}};
            last_r  <= {IW{1'b0}};
            acc_r   <= {RW{1'b0}};
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            idx_r   <= idx_s;
            last_r  <= last_s;
            acc_r   <= acc_s;
        end
    end

    assign InReady  = in_ready_s;
    assign OutValid = (state_r == DONE);
    assign Result   = acc_r;
    assign Busy     = (state_r != IDLE);

endmodule

// File: tb/tb_popcnt_seq.sv
// Directed self-checking bench for popcnt_seq (default 64/16 configuration).
module tb_popcnt_seq;

    logic        clk;
    logic        reset_n;
    logic        InValid;
    logic        InReady;
    logic [63:0] A;
    logic        W32;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [6:0]  Result;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    popcnt_seq #(.XLEN(64), .CHUNK(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .W32      (W32),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Busy     (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept edge counts as cycle 1; returns the cycle on which OutValid is first seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!OutValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input logic [63:0] a, input logic w);
        InValid = 1'b1;
        A       = a;
        W32     = w;
        @(posedge clk); #1;
        InValid = 1'b0;
        A       = 64'h0;
        W32     = 1'b0;
    endtask

    task automatic no_valid_for(input string tag, input int n);
        int rises;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (OutValid) rises++;
        end
        chk(tag, 32'(rises), 32'd0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic        w;
        int          res;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs[7];
    int   lat;
    int   exp_lat;

    initial begin
        vecs[0] = '{64'hFFFF_0000_F0F0_0001, 1'b0, 25, 5, 5};
        vecs[1] = '{64'hFFFF_FFFF_8000_0003, 1'b1,  3, 3, 3};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 5, 5};
        vecs[3] = '{64'h0000_0000_0000_0000, 1'b0,  0, 5, 2};
        vecs[4] = '{64'h0000_0000_0000_00FF, 1'b0,  8, 5, 2};
        vecs[5] = '{64'h8000_0000_0000_0000, 1'b0,  1, 5, 5};
        vecs[6] = '{64'hFFFF_FFFF_0000_0000, 1'b1,  0, 3, 2};

        reset_n  = 1'b0;
        InValid  = 1'b0;
        A        = 64'h0;
        W32      = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        #12;
        chk("rst_inready",  32'(InReady),  32'd1);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_result",   32'(Result),   32'd0);
        chk("rst_busy",     32'(Busy),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with full handshake.
        foreach (vecs[i]) begin
`ifdef POPCNT_SEQ_EARLY_EXIT_EN
            exp_lat = vecs[i].lat_early;
`else
            exp_lat = vecs[i].lat_fixed;
`endif
            chk($sformatf("v%0d_inready", i), 32'(InReady), 32'd1);
            accept(vecs[i].a, vecs[i].w);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("v%0d_result", i), 32'(Result), 32'(vecs[i].res));
            @(posedge clk); #1;
            chk($sformatf("v%0d_retired", i), 32'(OutValid), 32'd0);
        end

        // Consumer stall: result held, no new request accepted.
        OutReady = 1'b0;
        accept(64'h0000_0000_0000_0003, 1'b0);
        wait_done(lat);
        chk("stall_first", 32'(OutValid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", i),   32'(OutValid), 32'd1);
            chk($sformatf("stall%0d_result", i),  32'(Result),   32'd2);
            chk($sformatf("stall%0d_inready", i), 32'(InReady),  32'd0);
        end
        OutReady = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", 32'(OutValid), 32'd0);
        chk("stall_idle",    32'(InReady),  32'd1);

        // Back-to-back: second request accepted in the DONE cycle.
        accept(64'hFFFF_0000_F0F0_0001, 1'b0);
        wait_done(lat);
        chk("b2b_first_result", 32'(Result),  32'd25);
        chk("b2b_inready",      32'(InReady), 32'd1);
        accept(64'h0000_0000_0000_0001, 1'b0);
        chk("b2b_busy", 32'(Busy), 32'd1);
        wait_done(lat);
`ifdef POPCNT_SEQ_EARLY_EXIT_EN
        chk("b2b_latency", 32'(lat), 32'd2);
`else
        chk("b2b_latency", 32'(lat), 32'd5);
`endif
        chk("b2b_second_result", 32'(Result), 32'd1);
        @(posedge clk); #1;

        // Flush in the second COUNT cycle.
        accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        chk("flush_mid_partial", 32'(Result), 32'd16);
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        chk("flush_busy",     32'(Busy),     32'd0);
        chk("flush_outvalid", 32'(OutValid), 32'd0);
        chk("flush_result",   32'(Result),   32'd0);
        chk("flush_inready",  32'(InReady),  32'd1);
        no_valid_for("flush_no_valid", 8);

        // Flush coinciding with a request in IDLE drops the request.
        InValid = 1'b1;
        A       = 64'hFFFF_FFFF_FFFF_FFFF;
        Flush   = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        Flush   = 1'b0;
        chk("flush_drop_busy", 32'(Busy), 32'd0);
        no_valid_for("flush_drop_no_valid", 8);

        // Asynchronous reset mid-COUNT.
        accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy",     32'(Busy),     32'd0);
        chk("arst_outvalid", 32'(OutValid), 32'd0);
        chk("arst_result",   32'(Result),   32'd0);
        chk("arst_inready",  32'(InReady),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        no_valid_for("arst_no_valid", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
